// File: rtl/sap_pkg.sv
// Shared opcodes, T-state encoding and control-word layout
// for the SAP control sequencer and its microcode decoder.
package sap_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int OPCODE_WIDTH = 4;
    localparam int NUM_STEPS    = 5;
    localparam int STEP_WIDTH   = 3;

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP = 4'h0;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 4'h1;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'h2;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'h3;
    localparam logic [OPCODE_WIDTH-1:0] OP_STA = 4'h4;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI = 4'h5;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 4'h6;
    localparam logic [OPCODE_WIDTH-1:0] OP_JC  = 4'h7;
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = 4'h8;
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 4'hF;

    localparam int CW_PC_OUT     = 0;
    localparam int CW_PC_INC     = 1;
    localparam int CW_JUMP       = 2;
    localparam int CW_MAR_LOAD   = 3;
    localparam int CW_RAM_OUT    = 4;
    localparam int CW_RAM_LOAD   = 5;
    localparam int CW_IR_LOAD    = 6;
    localparam int CW_IR_OUT     = 7;
    localparam int CW_A_LOAD     = 8;
    localparam int CW_A_OUT      = 9;
    localparam int CW_B_LOAD     = 10;
    localparam int CW_ALU_OUT    = 11;
    localparam int CW_ALU_SUB    = 12;
    localparam int CW_FLAGS_LOAD = 13;
    localparam int CW_OUT_LOAD   = 14;
    localparam int CW_HALT       = 15;
    localparam int CW_WIDTH      = 16;

    typedef enum logic [STEP_WIDTH-1:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_e;

    typedef logic [CW_WIDTH-1:0] cw_t;

endpackage

// File: rtl/sap_microcode_decode.sv
// Combinational microcode ROM: {opcode, step, flags} to control word.
// CW_HALT is an internal strobe that sets the halt latch.
module sap_microcode_decode
    import sap_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  step_e                   step,
    input  logic                    flag_c,
    input  logic                    flag_z,
    output cw_t                     cw
);

    always_comb begin
        cw = '0;
        unique case (step)
            T0: begin
                cw[CW_PC_OUT]   = 1'b1;
                cw[CW_MAR_LOAD] = 1'b1;
            end
            T1: begin
                cw[CW_RAM_OUT] = 1'b1;
                cw[CW_IR_LOAD] = 1'b1;
                cw[CW_PC_INC]  = 1'b1;
            end
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw[CW_IR_OUT]   = 1'b1;
                        cw[CW_MAR_LOAD] = 1'b1;
                    end
                    OP_LDI: begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_A_LOAD] = 1'b1;
                    end
                    OP_JMP: begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_JUMP]   = 1'b1;
                    end
                    OP_JC: begin
                        cw[CW_IR_OUT] = flag_c;
                        cw[CW_JUMP]   = flag_c;
                    end
                    OP_JZ: begin
                        cw[CW_IR_OUT] = flag_z;
                        cw[CW_JUMP]   = flag_z;
                    end
                    OP_OUT: begin
                        cw[CW_A_OUT]    = 1'b1;
                        cw[CW_OUT_LOAD] = 1'b1;
                    end
                    OP_HLT: cw[CW_HALT] = 1'b1;
                    default: cw = '0;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_A_LOAD]  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_B_LOAD]  = 1'b1;
                    end
                    OP_STA: begin
                        cw[CW_A_OUT]    = 1'b1;
                        cw[CW_RAM_LOAD] = 1'b1;
                    end
                    default: cw = '0;
                endcase
            end
            T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    cw[CW_ALU_OUT]    = 1'b1;
                    cw[CW_A_LOAD]     = 1'b1;
                    cw[CW_FLAGS_LOAD] = 1'b1;
                    cw[CW_ALU_SUB]    = (opcode == OP_SUB);
                end
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP control unit: IR, T-state counter, flags and halt latch,
// with reset/halt gating of the decoded control word.
module sap_control_sequencer
    import sap_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] bus,
    input  logic                  cf,
    input  logic                  zf,
    output logic                  pc_out,
    output logic                  pc_inc,
    output logic                  jump,
    output logic                  mar_load,
    output logic                  ram_out,
    output logic                  ram_load,
    output logic                  ir_load,
    output logic                  ir_out,
    output logic [3:0]            ir_operand,
    output logic                  a_load,
    output logic                  a_out,
    output logic                  b_load,
    output logic                  alu_out,
    output logic                  alu_sub,
    output logic                  flags_load,
    output logic                  out_load,
    output logic                  halt,
    output logic [STEP_WIDTH-1:0] step
);

    step_e                 step_q;
    logic [DATA_WIDTH-1:0] ir_q;
    logic                  flag_c_q;
    logic                  flag_z_q;
    logic                  halted_q;
    cw_t                   cw;
    cw_t                   cw_g;

    sap_microcode_decode u_decode (
        .opcode (ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH]),
        .step   (step_q),
        .flag_c (flag_c_q),
        .flag_z (flag_z_q),
        .cw     (cw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q   <= T0;
            ir_q     <= '0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            step_q <= (step_q == T4) ? T0 : step_e'(step_q + 3'd1);
            if (cw[CW_IR_LOAD])
                ir_q <= bus;
            if (cw[CW_FLAGS_LOAD]) begin
                flag_c_q <= cf;
                flag_z_q <= zf;
            end
            if (cw[CW_HALT])
                halted_q <= 1'b1;
        end
    end

    // Reset and halt both silence every control line immediately.
    assign cw_g = (rst || halted_q) ? '0 : cw;

    assign pc_out     = cw_g[CW_PC_OUT];
    assign pc_inc     = cw_g[CW_PC_INC];
    assign jump       = cw_g[CW_JUMP];
    assign mar_load   = cw_g[CW_MAR_LOAD];
    assign ram_out    = cw_g[CW_RAM_OUT];
    assign ram_load   = cw_g[CW_RAM_LOAD];
    assign ir_load    = cw_g[CW_IR_LOAD];
    assign ir_out     = cw_g[CW_IR_OUT];
    assign a_load     = cw_g[CW_A_LOAD];
    assign a_out      = cw_g[CW_A_OUT];
    assign b_load     = cw_g[CW_B_LOAD];
    assign alu_out    = cw_g[CW_ALU_OUT];
    assign alu_sub    = cw_g[CW_ALU_SUB];
    assign flags_load = cw_g[CW_FLAGS_LOAD];
    assign out_load   = cw_g[CW_OUT_LOAD];
    assign ir_operand = ir_q[3:0];
    assign halt       = halted_q & ~rst;
    assign step       = step_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for sap_control_sequencer: a per-cycle instruction-level
// model plus hand-computed spot checks at key T-states.
module tb_sap_control_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus;
    logic       cf, zf;
    logic       pc_out, pc_inc, jump, mar_load, ram_out, ram_load;
    logic       ir_load, ir_out, a_load, a_out, b_load, alu_out;
    logic       alu_sub, flags_load, out_load, halt;
    logic [3:0] ir_operand;
    logic [2:0] step;

    int n_checks = 0;
    int n_fail   = 0;

    sap_control_sequencer dut (
        .clk(clk), .rst(rst), .bus(bus), .cf(cf), .zf(zf),
        .pc_out(pc_out), .pc_inc(pc_inc), .jump(jump),
        .mar_load(mar_load), .ram_out(ram_out), .ram_load(ram_load),
        .ir_load(ir_load), .ir_out(ir_out), .ir_operand(ir_operand),
        .a_load(a_load), .a_out(a_out), .b_load(b_load),
        .alu_out(alu_out), .alu_sub(alu_sub), .flags_load(flags_load),
        .out_load(out_load), .halt(halt), .step(step)
    );

    always #5 clk = ~clk;

    // Bench-side control vector order, MSB first.
    localparam logic [14:0] PCO = 15'h4000, PCI = 15'h2000, JMP = 15'h1000;
    localparam logic [14:0] MAR = 15'h0800, RO  = 15'h0400, RL  = 15'h0200;
    localparam logic [14:0] IRL = 15'h0100, IRO = 15'h0080, AL  = 15'h0040;
    localparam logic [14:0] AO  = 15'h0020, BL  = 15'h0010, ALO = 15'h0008;
    localparam logic [14:0] SUB = 15'h0004, FL  = 15'h0002, OL  = 15'h0001;

    function automatic logic [14:0] exp_ctrl(input logic [3:0] op, input int s,
                                             input logic c, input logic z);
        logic [14:0] r;
        r = '0;
        if (s == 0) r = PCO | MAR;
        else if (s == 1) r = RO | IRL | PCI;
        else begin
            case (op)
                4'h1: r = (s == 2) ? (IRO | MAR) : (s == 3) ? (RO | AL) : 15'h0;
                4'h2, 4'h3:
                    r = (s == 2) ? (IRO | MAR) : (s == 3) ? (RO | BL) :
                        (ALO | AL | FL | ((op == 4'h3) ? SUB : 15'h0));
                4'h4: r = (s == 2) ? (IRO | MAR) : (s == 3) ? (AO | RL) : 15'h0;
                4'h5: r = (s == 2) ? (IRO | AL) : 15'h0;
                4'h6: r = (s == 2) ? (IRO | JMP) : 15'h0;
                4'h7: r = (s == 2 && c) ? (IRO | JMP) : 15'h0;
                4'h8: r = (s == 2 && z) ? (IRO | JMP) : 15'h0;
                4'hE: r = (s == 2) ? (AO | OL) : 15'h0;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    int         m_step = 0;
    logic [7:0] m_ir   = '0;
    logic       m_c = 1'b0, m_z = 1'b0, m_halted = 1'b0;

    always @(posedge clk) begin
        logic [14:0] e;
        e = exp_ctrl(m_ir[7:4], m_step, m_c, m_z);
        if (rst) begin
            m_step   <= 0;
            m_ir     <= '0;
            m_c      <= 1'b0;
            m_z      <= 1'b0;
            m_halted <= 1'b0;
        end else if (!m_halted) begin
            m_step <= (m_step + 1) % 5;
            if ((e & IRL) != 0) m_ir <= bus;
            if ((e & FL) != 0) begin
                m_c <= cf;
                m_z <= zf;
            end
            if (m_ir[7:4] == 4'hF && m_step == 2) m_halted <= 1'b1;
        end
    end

    logic [14:0] act_ctrl;
    assign act_ctrl = {pc_out, pc_inc, jump, mar_load, ram_out, ram_load,
                       ir_load, ir_out, a_load, a_out, b_load, alu_out,
                       alu_sub, flags_load, out_load};

    always @(negedge clk) begin
        logic [14:0] e;
        logic [22:0] exp_v, act_v;
        int drivers;
        if (rst === 1'b0 || rst === 1'b1) begin
            e = (rst || m_halted) ? 15'h0 : exp_ctrl(m_ir[7:4], m_step, m_c, m_z);
            exp_v = {e, m_halted & ~rst, 3'(m_step), m_ir[3:0]};
            act_v = {act_ctrl, halt, step, ir_operand};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL model t=%0t got=%h want=%h", $time, act_v, exp_v);
            end
            drivers = int'(pc_out) + int'(ram_out) + int'(ir_out)
                    + int'(a_out) + int'(alu_out);
            n_checks++;
            if (drivers > 1) begin
                n_fail++;
                $display("FAIL bus_drivers t=%0t got=%0d want<=1", $time, drivers);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic spot();
        @(negedge clk);
        #1;
    endtask

    task automatic run(input logic [7:0] instr, input logic c, input logic z);
        bus = instr;
        cf  = c;
        zf  = z;
        cyc(5);
    endtask

    initial begin
        rst = 1'b1; bus = '0; cf = 1'b0; zf = 1'b0;
        cyc(1);
        spot(); chk("rst_ctrl", {7'h0, |act_ctrl}, 8'h0);
        chk("rst_halt_step", {4'h0, halt, step}, 8'h0);
        cyc(1);
        rst = 1'b0;
        bus = 8'h1E;
        spot(); chk("t0_fetch", {6'h0, pc_out, mar_load}, 8'h03);
        cyc(1);
        spot(); chk("t1_fetch", {5'h0, ram_out, ir_load, pc_inc}, 8'h07);
        cyc(1);
        spot(); chk("t2_operand", {4'h0, ir_operand}, 8'h0E);
        chk("lda_t2", {6'h0, ir_out, mar_load}, 8'h03);
        cyc(3);

        bus = 8'h2F; cf = 1'b0; zf = 1'b1;
        cyc(4);
        spot(); chk("add_t4", {4'h0, alu_out, a_load, flags_load, alu_sub}, 8'h0E);
        cyc(1);
        spot(); chk("add_next_step", {5'h0, step}, 8'h00);

        run(8'h30, 1'b1, 1'b1);
        bus = 8'h83;
        cyc(2);
        spot(); chk("jz_taken", {6'h0, ir_out, jump}, 8'h03);
        cyc(3);

        run(8'h21, 1'b0, 1'b0);
        bus = 8'h75;
        cyc(2);
        for (int i = 0; i < 3; i++) begin
            spot(); chk("jc_not_taken", {7'h0, |act_ctrl}, 8'h0);
            cyc(1);
        end

        bus = 8'hA5;
        cyc(2);
        for (int i = 0; i < 3; i++) begin
            spot(); chk("opA_idle", {7'h0, |act_ctrl}, 8'h0);
            cyc(1);
        end
        spot(); chk("opA_len", {5'h0, step}, 8'h00);

        run(8'h43, 1'b0, 1'b0);
        run(8'h57, 1'b0, 1'b0);
        run(8'h69, 1'b0, 1'b0);
        run(8'hE0, 1'b0, 1'b0);
        run(8'h34, 1'b1, 1'b0);
        run(8'h7A, 1'b0, 1'b0);
        run(8'h8B, 1'b0, 1'b0);

        bus = 8'h1C;
        cyc(3);
        spot(); chk("lda_t3", {6'h0, ram_out, a_load}, 8'h03);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        spot(); chk("rst_mid_step", {5'h0, step}, 8'h00);
        chk("rst_mid_ir", {4'h0, ir_operand}, 8'h00);
        chk("rst_mid_aload", {7'h0, a_load}, 8'h00);

        bus = 8'hF0;
        cyc(3);
        for (int i = 0; i < 10; i++) begin
            spot(); chk("halted", {4'h0, halt, step}, 8'h0B);
            cyc(1);
        end
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        bus = 8'h00;
        spot(); chk("unhalt", {5'h0, halt, pc_out, mar_load}, 8'h03);
        cyc(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
Microcoded control unit for the 8-bit bus computer. It holds the instruction register, a 5-step T-state counter, the carry/zero flags register and the halt latch. Each cycle it decodes opcode, step and flags into the one-hot-per-role control word. That word drives the accumulator (a_load, a_out), the ALU, the B register, the PC, the MAR, RAM and the output register. It sits directly upstream of the accumulator and ALU.

Parameters:
DATA_WIDTH, 8, bus width; the instruction is {opcode, operand}.
OPCODE_WIDTH, 4, upper bits of the instruction.
NUM_STEPS, 5, T-states per instruction (T0..T4).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
bus  in  8  shared bus; sampled into IR when ir_load=1
cf  in  1  ALU carry out
zf  in  1  ALU zero flag
pc_out  out  1  PC drives bus
pc_inc  out  1  PC increments
jump  out  1  PC loads from bus
mar_load  out  1  MAR loads from bus
ram_out  out  1  RAM drives bus
ram_load  out  1  RAM writes from bus
ir_load  out  1  IR loads from bus (internal IR)
ir_out  out  1  operand nibble drives bus (external tri-state)
ir_operand  out  4  IR[3:0]
a_load  out  1  accumulator load
a_out  out  1  accumulator enable_output
b_load  out  1  B register load
alu_out  out  1  ALU enable_output
alu_sub  out  1  ALU subtract select
flags_load  out  1  internal flags capture cf/zf
out_load  out  1  output register load
halt  out  1  CPU halted
step  out  3  current T-state (debug)

Behaviour:
- Reset, while rst=1 at the edge: step=0, IR=0x00, flag_c=0, flag_z=0, halted=0.
- While rst is high, every control output is forced to 0 and halt=0. ir_operand reflects IR.
- Control outputs are combinational from registered {step, IR[7:4], flag_c, flag_z, halted}. There is no extra latency. A load asserted in step k takes effect at the rising edge that ends step k.
- Step counter: 0→1→2→3→4→0. Every instruction takes exactly 5 cycles; there is no early termination.
- Fetch, all opcodes:
  - T0: pc_out, mar_load.
  - T1: ram_out, ir_load, pc_inc.
- IR captures bus at the T1 edge.
- Execute, T2/T3/T4 (unlisted step = all zero):
  - NOP 0x0: nothing.
  - LDA 0x1: T2 ir_out+mar_load; T3 ram_out+a_load.
  - ADD 0x2: T2 ir_out+mar_load; T3 ram_out+b_load; T4 alu_out+a_load+flags_load.
  - SUB 0x3: as ADD, with alu_sub=1 at T4.
  - STA 0x4: T2 ir_out+mar_load; T3 a_out+ram_load.
  - LDI 0x5: T2 ir_out+a_load.
  - JMP 0x6: T2 ir_out+jump.
  - JC 0x7: T2 ir_out+jump only if flag_c=1, else nothing.
  - JZ 0x8: T2 ir_out+jump only if flag_z=1, else nothing.
  - OUT 0xE: T2 a_out+out_load.
  - HLT 0xF: T2 sets halted at the edge.
  - 0x9–0xD: treated as NOP.
- Flags: flag_c/flag_z capture cf/zf at the edge where flags_load=1; otherwise they hold.
- Halted:
  - step frozen, IR and flags hold.
  - all control outputs 0, halt=1.
  - exit only via rst.
- Invariant: at most one bus driver (pc_out, ram_out, ir_out, a_out, alu_out) asserted in any cycle.
- Reset mid-instruction: the next cycle is T0 with IR=0. No partial-step side effects beyond signals already issued.

Decomposition:
- Package sap_pkg:
  - opcode localparams (OP_NOP..OP_HLT).
  - control-word bit indices and CW_WIDTH.
  - NUM_STEPS.
- Sub-module sap_microcode_decode: purely combinational {opcode, step, flag_c, flag_z} → control word.
- The sequencer holds the step counter, IR, flags and halt latch, and applies the rst/halt gating.

Test Plan:
- Reset and fetch:
  - Stimulus: rst=1 for 2 cycles, then release.
  - Response: all controls 0 during reset. T0 gives pc_out=mar_load=1. T1 gives ram_out=ir_load=pc_inc=1. bus=0x1E at T1 gives ir_operand=0xE at T2.
- ADD 0x2F:
  - T2 ir_out+mar_load.
  - T3 ram_out+b_load.
  - T4 alu_out+a_load+flags_load, alu_sub=0.
  - Next cycle step=0.
- Flags and jumps:
  - Set up: SUB with cf=1, zf=1 at T4.
  - JZ 0x83: ir_out+jump at T2.
  - After an ADD with cf=0, zf=0, JC 0x75: no jump, T2–T4 all zero.
- HLT 0xF0:
  - halt=1 from T3 onward, all controls 0, step frozen for 10 cycles.
  - Then rst pulse: halt=0, T0 fetch resumes.
- Reset during LDA T3:
  - Apply rst at that edge.
  - Next cycle: step=0, IR=0, a_load not re-issued. A checker asserts the single-bus-driver invariant throughout.
- Opcode 0xA:
  - T2–T4 produce no control activity.
  - The instruction completes in 5 cycles.
